// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 phase lengths, totals and the phase enum used by
// both the horizontal and vertical raster state machines.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

  // Last in-phase count value of phase p, given the four phase lengths.
  function automatic logic [9:0] phase_last(input phase_e p, input int act,
                                            input int fp, input int sync,
                                            input int bp);
    int len_v;
    case (p)
      ACT:     len_v = act;
      FP:      len_v = fp;
      SYNC:    len_v = sync;
      BP:      len_v = bp;
      default: len_v = act;
    endcase
    return 10'(len_v - 1);
  endfunction

  function automatic phase_e phase_succ(input phase_e p);
    phase_e n_v;
    case (p)
      ACT:     n_v = FP;
      FP:      n_v = SYNC;
      SYNC:    n_v = BP;
      BP:      n_v = ACT;
      default: n_v = ACT;
    endcase
    return n_v;
  endfunction

endpackage

// File: rtl/vga_pix_en.sv
// Pixel-rate divider: PIX_EN is high in the last CLK of every CLK_DIV-cycle
// pixel slot, and forced low while RST is held.
module vga_pix_en #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic PIX_EN
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_r;

  // Free-running pixel-slot counter, wraps at CLK_DIV-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_r <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Gating with RST keeps the CLK_DIV = 1 case quiet during reset.
  assign PIX_EN = ~RST & (div_r == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical phase FSMs, pixel counters and
// registered sync/blanking outputs, all advancing on the PIX_EN strobe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       PIX_EN,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       HS,
  output logic       VS,
  output logic       VIDEO_ON,
  output logic       LINE_START,
  output logic       FRAME_START
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_check
      $error("vga_timing_gen: H/V totals must fit the 10-bit counters");
    end
  endgenerate

  logic       pix_en_s;
  logic       line_adv_s;
  phase_e     h_state_r, h_state_s, v_state_r, v_state_s;
  logic [9:0] h_cnt_r, h_cnt_s, v_cnt_r, v_cnt_s;
  logic [9:0] x_r, x_s, y_r, y_s;
  logic       hs_r, vs_r, video_on_r;

  vga_pix_en #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .CLK    (CLK),
    .RST    (RST),
    .PIX_EN (pix_en_s)
  );

  assign line_adv_s = pix_en_s & (x_r == H_LAST);

  // Horizontal phase FSM next state and column counter.
  always_comb begin
    h_state_s = h_state_r;
    h_cnt_s   = h_cnt_r;
    x_s       = x_r;
    if (pix_en_s) begin
      x_s = (x_r == H_LAST) ? 10'd0 : x_r + 10'd1;
      if (h_cnt_r == phase_last(h_state_r, H_ACTIVE, H_FP, H_SYNC, H_BP)) begin
        h_state_s = phase_succ(h_state_r);
        h_cnt_s   = 10'd0;
      end else begin
        h_cnt_s   = h_cnt_r + 10'd1;
      end
    end else begin
      x_s = x_r;
    end
  end

  // Vertical phase FSM next state and line counter, stepping once per line.
  always_comb begin
    v_state_s = v_state_r;
    v_cnt_s   = v_cnt_r;
    y_s       = y_r;
    if (line_adv_s) begin
      y_s = (y_r == V_LAST) ? 10'd0 : y_r + 10'd1;
      if (v_cnt_r == phase_last(v_state_r, V_ACTIVE, V_FP, V_SYNC, V_BP)) begin
        v_state_s = phase_succ(v_state_r);
        v_cnt_s   = 10'd0;
      end else begin
        v_cnt_s   = v_cnt_r + 10'd1;
      end
    end else begin
      y_s = y_r;
    end
  end

  // State, counters and sync/blank outputs; outputs come from next state so
  // they change on the same edge as X/Y.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_state_r  <= ACT;
      v_state_r  <= ACT;
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 10'd0;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      hs_r       <= 1'b1;
      vs_r       <= 1'b1;
      video_on_r <= 1'b1;
    end else begin
      h_state_r  <= h_state_s;
      v_state_r  <= v_state_s;
      h_cnt_r    <= h_cnt_s;
      v_cnt_r    <= v_cnt_s;
      x_r        <= x_s;
      y_r        <= y_s;
      hs_r       <= (h_state_s != SYNC);
      vs_r       <= (v_state_s != SYNC);
      video_on_r <= (h_state_s == ACT) && (v_state_s == ACT);
    end
  end

  assign PIX_EN      = pix_en_s;
  assign X           = x_r;
  assign Y           = y_r;
  assign HS          = hs_r;
  assign VS          = vs_r;
  assign VIDEO_ON    = video_on_r;
  assign LINE_START  = line_adv_s;
  assign FRAME_START = line_adv_s & (y_r == V_LAST);

endmodule
